// File: rtl/evm_pkg.sv
// Shared definitions for the voting session controller and its helpers:
// FSM state encoding, reject reason codes and default poll sizes.
package evm_pkg;

  localparam int DEF_NUM_CANDIDATES = 3;
  localparam int DEF_NUM_VOTERS     = 4;

  localparam logic [2:0] REJ_NONE     = 3'd0;
  localparam logic [2:0] REJ_CLOSED   = 3'd1;
  localparam logic [2:0] REJ_VOTER    = 3'd2;
  localparam logic [2:0] REJ_CAND     = 3'd3;
  localparam logic [2:0] REJ_DUP      = 3'd4;
  localparam logic [2:0] REJ_TIMEOUT  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_CHECK,
    ST_CAST,
    ST_CONFIRM,
    ST_RESP,
    ST_CLOSED
  } state_t;

endpackage

// File: rtl/evm_session_controller_if.sv
// Bundle of poll control, vote request handshake and memory-side signals
// shared between the session controller and whoever drives it.
interface evm_session_controller_if #(
  parameter int ID_W       = 4,
  parameter int NUM_VOTERS = 4,
  parameter int CNT_W      = 4
);

  logic                  poll_open;
  logic                  poll_close;
  logic                  vote_req;
  logic [ID_W-1:0]       voter_id;
  logic [ID_W-1:0]       candidate_number;
  logic [NUM_VOTERS-1:0] voter_status;
  logic [ID_W-1:0]       mem_voter_id;
  logic [ID_W-1:0]       mem_candidate;
  logic                  vote_cast;
  logic                  vote_ack;
  logic                  vote_reject;
  logic [2:0]            reject_code;
  logic                  busy;
  logic                  poll_active;
  logic                  results_valid;
  logic [CNT_W-1:0]      total_votes;

  modport master (
    output poll_open, poll_close, vote_req, voter_id, candidate_number, voter_status,
    input  mem_voter_id, mem_candidate, vote_cast, vote_ack, vote_reject,
           reject_code, busy, poll_active, results_valid, total_votes
  );

  modport slave (
    input  poll_open, poll_close, vote_req, voter_id, candidate_number, voter_status,
    output mem_voter_id, mem_candidate, vote_cast, vote_ack, vote_reject,
           reject_code, busy, poll_active, results_valid, total_votes
  );

endinterface

// File: rtl/evm_vote_validator.sv
// Combinational ballot check: voter ID range, candidate range and the
// "already voted" flag, in that priority. The status vector is only ever
// read through an equality scan, so an out-of-range ID never indexes it.
module evm_vote_validator
  import evm_pkg::*;
#(
  parameter int NUM_CANDIDATES = DEF_NUM_CANDIDATES,
  parameter int NUM_VOTERS     = DEF_NUM_VOTERS,
  parameter int ID_W           = 4
) (
  input  logic [ID_W-1:0]       i_voterId,
  input  logic [ID_W-1:0]       i_candidate,
  input  logic [NUM_VOTERS-1:0] i_voterStatus,
  output logic                  o_ok,
  output logic [2:0]            o_rejectCode,
  output logic                  o_alreadyVoted
);

  logic [31:0] w_idExt;
  logic [31:0] w_candExt;
  logic        w_idOk;
  logic        w_candOk;
  logic        w_statusBit;

  // Range checks and a safe lookup of the selected voter's status flag
  always_comb begin
    w_idExt     = {{(32-ID_W){1'b0}}, i_voterId};
    w_candExt   = {{(32-ID_W){1'b0}}, i_candidate};
    w_idOk      = (w_idExt < 32'(NUM_VOTERS));
    w_candOk    = (w_candExt < 32'(NUM_CANDIDATES));
    w_statusBit = 1'b0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      if (w_idExt == 32'(i)) begin
        w_statusBit = i_voterStatus[i];
      end
    end
  end

  // Prioritised reason code; ok only when every check passes
  always_comb begin
    o_ok           = 1'b0;
    o_rejectCode   = REJ_NONE;
    o_alreadyVoted = w_idOk & w_statusBit;
    if (!w_idOk) begin
      o_rejectCode = REJ_VOTER;
    end else if (!w_candOk) begin
      o_rejectCode = REJ_CAND;
    end else if (w_statusBit) begin
      o_rejectCode = REJ_DUP;
    end else begin
      o_ok = 1'b1;
    end
  end

endmodule

// File: rtl/evm_session_controller.sv
// Front-end sequencer for the voting memory: opens/closes the poll, takes one
// vote request at a time, validates it, strobes the memory write, waits for
// the voter's status flag to confirm the write and counts accepted ballots.
// All outputs are registered and decoded from the state being entered.
module evm_session_controller
  import evm_pkg::*;
#(
  parameter int NUM_CANDIDATES  = DEF_NUM_CANDIDATES,
  parameter int NUM_VOTERS      = DEF_NUM_VOTERS,
  parameter int ID_W            = 4,
  parameter int CNT_W           = 4,
  parameter int CONFIRM_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  evm_session_controller_if.slave bus
);

  localparam int TMO_W = $clog2(CONFIRM_TIMEOUT + 1);

  state_t             r_state;
  state_t             r_retState;
  logic               r_armed;
  logic               r_pendingClose;
  logic [TMO_W-1:0]   r_tmoCnt;
  logic [2:0]         r_rejCode;
  logic               r_isAck;
  logic [ID_W-1:0]    r_memVoterId;
  logic [ID_W-1:0]    r_memCand;
  logic               r_voteCast;
  logic               r_voteAck;
  logic               r_voteReject;
  logic [2:0]         r_rejectCode;
  logic               r_busy;
  logic               r_pollActive;
  logic               r_resultsValid;
  logic [CNT_W-1:0]   r_totalVotes;

  state_t             w_nextState;
  state_t             w_nextRet;
  logic               w_nextPendingClose;
  logic [TMO_W-1:0]   w_nextTmo;
  logic [TMO_W-1:0]   w_tmoInc;
  logic [2:0]         w_nextCode;
  logic               w_nextIsAck;
  logic               w_accept;
  logic               w_countVote;
  logic               w_valOk;
  logic [2:0]         w_valCode;
  logic               w_voted;

  // Checks always look at the latched request, which is what memory sees
  evm_vote_validator #(
    .NUM_CANDIDATES (NUM_CANDIDATES),
    .NUM_VOTERS     (NUM_VOTERS),
    .ID_W           (ID_W)
  ) u_validator (
    .i_voterId      (r_memVoterId),
    .i_candidate    (r_memCand),
    .i_voterStatus  (bus.voter_status),
    .o_ok           (w_valOk),
    .o_rejectCode   (w_valCode),
    .o_alreadyVoted (w_voted)
  );

  // Next-state logic plus the response/return bookkeeping for RESP
  always_comb begin
    w_nextState        = r_state;
    w_nextRet          = r_retState;
    w_nextPendingClose = r_pendingClose;
    w_nextTmo          = r_tmoCnt;
    w_tmoInc           = TMO_W'(r_tmoCnt + 1'b1);
    w_nextCode         = r_rejCode;
    w_nextIsAck        = r_isAck;
    w_accept           = 1'b0;
    w_countVote        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.poll_open) begin
          w_nextState = ST_OPEN;
        end else if (bus.vote_req) begin
          w_nextState = ST_RESP;
          w_nextRet   = ST_IDLE;
          w_nextCode  = REJ_CLOSED;
          w_nextIsAck = 1'b0;
        end
      end
      ST_OPEN: begin
        if (bus.vote_req && r_armed) begin
          w_accept           = 1'b1;
          w_nextState        = ST_CHECK;
          w_nextRet          = ST_OPEN;
          w_nextPendingClose = r_pendingClose | bus.poll_close;
        end else if (bus.poll_close) begin
          w_nextState = ST_CLOSED;
        end
      end
      ST_CHECK: begin
        w_nextPendingClose = r_pendingClose | bus.poll_close;
        if (!w_valOk) begin
          w_nextState = ST_RESP;
          w_nextCode  = w_valCode;
          w_nextIsAck = 1'b0;
        end else begin
          w_nextState = ST_CAST;
        end
      end
      ST_CAST: begin
        w_nextPendingClose = r_pendingClose | bus.poll_close;
        w_nextState        = ST_CONFIRM;
        w_nextTmo          = '0;
      end
      ST_CONFIRM: begin
        w_nextPendingClose = r_pendingClose | bus.poll_close;
        if (w_voted) begin
          w_nextState = ST_RESP;
          w_nextCode  = REJ_NONE;
          w_nextIsAck = 1'b1;
          w_countVote = 1'b1;
        end else if (w_tmoInc == TMO_W'(CONFIRM_TIMEOUT)) begin
          w_nextState = ST_RESP;
          w_nextCode  = REJ_TIMEOUT;
          w_nextIsAck = 1'b0;
        end else begin
          w_nextTmo = w_tmoInc;
        end
      end
      ST_RESP: begin
        if (r_retState == ST_IDLE) begin
          w_nextState = ST_IDLE;
        end else if (r_retState == ST_CLOSED || r_pendingClose || bus.poll_close) begin
          w_nextState = ST_CLOSED;
        end else begin
          w_nextState = ST_OPEN;
        end
      end
      ST_CLOSED: begin
        if (bus.vote_req) begin
          w_nextState = ST_RESP;
          w_nextRet   = ST_CLOSED;
          w_nextCode  = REJ_CLOSED;
          w_nextIsAck = 1'b0;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register and control flags; a held request re-arms only once dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_retState     <= ST_IDLE;
      r_armed        <= 1'b1;
      r_pendingClose <= 1'b0;
      r_tmoCnt       <= '0;
      r_rejCode      <= REJ_NONE;
      r_isAck        <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_retState     <= w_nextRet;
      r_pendingClose <= w_nextPendingClose;
      r_tmoCnt       <= w_nextTmo;
      r_rejCode      <= w_nextCode;
      r_isAck        <= w_nextIsAck;
      if (w_accept) begin
        r_armed <= 1'b0;
      end else if (!bus.vote_req) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Moore outputs registered from the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_voteCast     <= 1'b0;
      r_voteAck      <= 1'b0;
      r_voteReject   <= 1'b0;
      r_rejectCode   <= REJ_NONE;
      r_busy         <= 1'b0;
      r_pollActive   <= 1'b0;
      r_resultsValid <= 1'b0;
    end else begin
      r_voteCast     <= (w_nextState == ST_CAST);
      r_voteAck      <= (w_nextState == ST_RESP) && w_nextIsAck;
      r_voteReject   <= (w_nextState == ST_RESP) && !w_nextIsAck;
      r_rejectCode   <= ((w_nextState == ST_RESP) && !w_nextIsAck) ? w_nextCode : REJ_NONE;
      r_busy         <= (w_nextState == ST_CHECK) || (w_nextState == ST_CAST) ||
                        (w_nextState == ST_CONFIRM) || (w_nextState == ST_RESP);
      r_pollActive   <= (w_nextState == ST_OPEN) || (w_nextState == ST_CHECK) ||
                        (w_nextState == ST_CAST) || (w_nextState == ST_CONFIRM) ||
                        ((w_nextState == ST_RESP) && (w_nextRet == ST_OPEN));
      r_resultsValid <= (w_nextState == ST_CLOSED);
    end
  end

  // Memory-facing latch of the accepted request and the saturating ballot count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_memVoterId <= '0;
      r_memCand    <= '0;
      r_totalVotes <= '0;
    end else begin
      if (w_accept) begin
        r_memVoterId <= bus.voter_id;
        r_memCand    <= bus.candidate_number;
      end
      if (w_countVote && (r_totalVotes != {CNT_W{1'b1}})) begin
        r_totalVotes <= r_totalVotes + 1'b1;
      end
    end
  end

  assign bus.mem_voter_id  = r_memVoterId;
  assign bus.mem_candidate = r_memCand;
  assign bus.vote_cast     = r_voteCast;
  assign bus.vote_ack      = r_voteAck;
  assign bus.vote_reject   = r_voteReject;
  assign bus.reject_code   = r_rejectCode;
  assign bus.busy          = r_busy;
  assign bus.poll_active   = r_pollActive;
  assign bus.results_valid = r_resultsValid;
  assign bus.total_votes   = r_totalVotes;

endmodule

// File: tb/tb_evm_session_controller.sv
// Scoreboard bench for the session controller. Each request is predicted by a
// poll-level model (poll state, who has voted, ballot tally) and queued; a
// monitor pops expectations whenever the DUT strobes ack/reject or vote_cast.
module tb_evm_session_controller;

  typedef struct {
    bit isAck;
    int code;
    int lat;
    int issue;
    bit cast;
    int expTotal;
    int memId;
    int memCand;
  } exp_t;

  logic clk;
  logic rst_n;
  logic memClear;
  logic memRespond;
  int   cycleCnt;
  int   checks;
  int   errors;
  int   castCount;
  int   modelCasts;

  int   pollSt;
  bit   voted [4];
  int   total;
  int   lastId;
  int   lastCand;

  exp_t sb [$];
  exp_t mon;

  evm_session_controller_if #(.ID_W(4), .NUM_VOTERS(4), .CNT_W(4)) bus ();

  evm_session_controller #(
    .NUM_CANDIDATES  (3),
    .NUM_VOTERS      (4),
    .ID_W            (4),
    .CNT_W           (4),
    .CONFIRM_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure response latency
  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Memory model: a cast for voter k sets status[k] on the following edge
  always @(posedge clk) begin
    if (memClear) begin
      bus.voter_status <= '0;
    end else if (bus.vote_cast && memRespond && (bus.mem_voter_id < 4'd4)) begin
      bus.voter_status[bus.mem_voter_id[1:0]] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input int actual, input int expected);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: cast strobes and responses are checked against the queue head
  always @(negedge clk) begin
    if (bus.vote_cast) begin
      castCount++;
      if (sb.size() == 0) begin
        reportFail("unexpected_cast", 1, 0);
      end else begin
        checkOutput("cast_expected", int'(sb[0].cast), 1);
        checkOutput("cast_latency", cycleCnt - sb[0].issue, 2);
      end
    end
    if (bus.vote_ack || bus.vote_reject) begin
      if (sb.size() == 0) begin
        reportFail("unexpected_resp", 1, 0);
      end else begin
        mon = sb.pop_front();
        checkOutput("resp_ack", int'(bus.vote_ack), int'(mon.isAck));
        checkOutput("resp_reject", int'(bus.vote_reject), int'(!mon.isAck));
        checkOutput("resp_code", int'(bus.reject_code), mon.code);
        if (mon.lat >= 0) checkOutput("resp_latency", cycleCnt - mon.issue, mon.lat);
        checkOutput("total_votes", int'(bus.total_votes), mon.expTotal);
        checkOutput("mem_voter_id", int'(bus.mem_voter_id), mon.memId);
        checkOutput("mem_candidate", int'(bus.mem_candidate), mon.memCand);
      end
    end
  end

  function automatic void modelReset();
    pollSt   = 0;
    total    = 0;
    lastId   = 0;
    lastCand = 0;
    for (int i = 0; i < 4; i++) voted[i] = 1'b0;
  endfunction

  // Poll-level prediction of one request's outcome
  function automatic exp_t predict(input int id, input int cand, input bit closeDuring);
    exp_t e;
    e.isAck = 1'b0;
    e.code  = 0;
    e.lat   = -1;
    e.cast  = 1'b0;
    e.issue = 0;
    if (pollSt != 1) begin
      e.code = 1;
    end else begin
      lastId   = id;
      lastCand = cand;
      e.lat    = 2;
      if (id >= 4)            e.code = 2;
      else if (cand >= 3)     e.code = 3;
      else if (voted[id])     e.code = 4;
      else begin
        e.cast = 1'b1;
        modelCasts++;
        if (memRespond) begin
          e.isAck   = 1'b1;
          e.lat     = 4;
          voted[id] = 1'b1;
          total     = (total < 15) ? total + 1 : 15;
        end else begin
          e.code = 5;
          e.lat  = -1;
        end
      end
      if (closeDuring) pollSt = 2;
    end
    e.expTotal = total;
    e.memId    = lastId;
    e.memCand  = lastCand;
    return e;
  endfunction

  // Issue one request, hold until answered (bounded), then release it
  task automatic applyStimulus(input int id, input int cand, input int closeAt, input int holdAfter);
    exp_t e;
    bit   got;
    @(negedge clk);
    e       = predict(id, cand, closeAt > 0);
    e.issue = cycleCnt;
    sb.push_back(e);
    bus.voter_id         = 4'(id);
    bus.candidate_number = 4'(cand);
    bus.vote_req         = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.poll_close = (k + 1 == closeAt);
      if (bus.vote_ack || bus.vote_reject) begin
        got = 1'b1;
        break;
      end
    end
    bus.poll_close = 1'b0;
    if (!got) begin
      reportFail("resp_timeout", 0, 1);
      sb.delete();
    end
    repeat (holdAfter) @(negedge clk);
    bus.vote_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n          = 1'b0;
    memClear       = 1'b1;
    bus.vote_req   = 1'b0;
    bus.poll_open  = 1'b0;
    bus.poll_close = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    memClear = 1'b0;
    modelReset();
  endtask

  task automatic pollOpen();
    @(negedge clk);
    bus.poll_open = 1'b1;
    @(negedge clk);
    bus.poll_open = 1'b0;
    if (pollSt == 0) pollSt = 1;
    checkOutput("poll_active_open", int'(bus.poll_active), 1);
    checkOutput("results_valid_open", int'(bus.results_valid), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vote_cast"}, int'(bus.vote_cast), 0);
    checkOutput({tag, "_vote_ack"}, int'(bus.vote_ack), 0);
    checkOutput({tag, "_vote_reject"}, int'(bus.vote_reject), 0);
    checkOutput({tag, "_reject_code"}, int'(bus.reject_code), 0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
    checkOutput({tag, "_poll_active"}, int'(bus.poll_active), 0);
    checkOutput({tag, "_results_valid"}, int'(bus.results_valid), 0);
    checkOutput({tag, "_total_votes"}, int'(bus.total_votes), 0);
    checkOutput({tag, "_mem_voter_id"}, int'(bus.mem_voter_id), 0);
    checkOutput({tag, "_mem_candidate"}, int'(bus.mem_candidate), 0);
  endtask

  initial begin
    int  castsBefore;
    bit  sawCast;
    checks               = 0;
    errors               = 0;
    castCount            = 0;
    modelCasts           = 0;
    rst_n                = 1'b0;
    memClear             = 1'b1;
    memRespond           = 1'b1;
    bus.vote_req         = 1'b0;
    bus.poll_open        = 1'b0;
    bus.poll_close       = 1'b0;
    bus.voter_id         = '0;
    bus.candidate_number = '0;
    modelReset();

    resetDut();
    checkAllZero("reset");

    $display("[TB] request before poll opens");
    applyStimulus(1, 0, 0, 0);

    pollOpen();
    $display("[TB] directed ballots");
    applyStimulus(1, 2, 0, 0);
    applyStimulus(1, 2, 0, 0);
    applyStimulus(7, 0, 0, 0);
    applyStimulus(0, 3, 0, 0);
    memRespond = 1'b0;
    applyStimulus(2, 0, 0, 0);
    memRespond = 1'b1;

    $display("[TB] held request");
    castsBefore = castCount;
    applyStimulus(0, 1, 0, 10);
    checkOutput("held_single_cast", castCount - castsBefore, 1);

    $display("[TB] randomized ballots");
    for (int n = 0; n < 25; n++) begin
      memRespond = ($urandom_range(0, 5) != 0);
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), 0, 0);
    end
    memRespond = 1'b1;

    $display("[TB] reset during CAST");
    resetDut();
    pollOpen();
    @(negedge clk);
    begin
      exp_t e;
      e       = predict(2, 1, 1'b0);
      e.issue = cycleCnt;
      sb.push_back(e);
    end
    bus.voter_id         = 4'd2;
    bus.candidate_number = 4'd1;
    bus.vote_req         = 1'b1;
    sawCast = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.vote_cast) begin
        sawCast = 1'b1;
        break;
      end
    end
    if (!sawCast) reportFail("cast_timeout", 0, 1);
    rst_n        = 1'b0;
    memClear     = 1'b1;
    bus.vote_req = 1'b0;
    @(negedge clk);
    checkAllZero("midreset");
    sb.delete();
    modelReset();
    rst_n    = 1'b1;
    memClear = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] close during CONFIRM");
    pollOpen();
    applyStimulus(3, 1, 3, 0);
    checkOutput("results_valid_closed", int'(bus.results_valid), 1);
    checkOutput("poll_active_closed", int'(bus.poll_active), 0);
    applyStimulus(2, 2, 0, 0);
    checkOutput("results_valid_after", int'(bus.results_valid), 1);

    checkOutput("cast_count", castCount, modelCasts);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
